// File: rtl/trena_pkg.sv
// Shared definitions for the tape-measure control unit: state codes,
// character-select codes and default timing constants.
package trena_pkg;

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARA     = 4'h1,
    TRIGGER     = 4'h2,
    ESPERA_ECHO = 4'h3,
    MEDE        = 4'h4,
    ARMAZENA    = 4'h5,
    TRANSMITE   = 4'h6,
    ESPERA_TX   = 4'h7,
    PROX_CHAR   = 4'h8,
    FINAL       = 4'h9,
    INTERVALO   = 4'hA,
    ERRO        = 4'hE
  } estado_t;

  localparam logic [1:0] CHAR_CENTENA = 2'd0;
  localparam logic [1:0] CHAR_DEZENA  = 2'd1;
  localparam logic [1:0] CHAR_UNIDADE = 2'd2;
  localparam logic [1:0] CHAR_HASH    = 2'd3;

  localparam int unsigned TRIGGER_CICLOS_PADRAO    = 500;
  localparam int unsigned TIMEOUT_CICLOS_PADRAO    = 1500000;
  localparam int unsigned INTERVALO_CICLOS_PADRAO  = 5000000;
  localparam int unsigned TX_TIMEOUT_CICLOS_PADRAO = 100000;

endpackage

// File: rtl/trena_controle_medicao_if.sv
// Control/datapath handshake bundle of the tape-measure control unit.
// master = control unit side, slave = datapath / sensor / serial TX side.
interface trena_controle_medicao_if;
  logic       mensurar;
  logic       periodico;
  logic       echo;
  logic       tx_pronto;
  logic       zera;
  logic       trigger;
  logic       conta;
  logic       registra;
  logic       partida_tx;
  logic [1:0] sel_char;
  logic       pronto;
  logic       erro;
  logic [3:0] db_estado;

  modport master (
    input  mensurar, periodico, echo, tx_pronto,
    output zera, trigger, conta, registra, partida_tx, sel_char,
           pronto, erro, db_estado
  );

  modport slave (
    output mensurar, periodico, echo, tx_pronto,
    input  zera, trigger, conta, registra, partida_tx, sel_char,
           pronto, erro, db_estado
  );
endinterface

// File: rtl/trena_controle_medicao_sincronizador.sv
// Two-flop synchronizer for the asynchronous sensor echo; clears to 0 on reset.
module sincronizador_2ff (
  input  logic clock,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);
  logic r_s1;
  logic r_s2;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;
endmodule

// File: rtl/trena_controle_medicao.sv
// Measurement sequencer: trigger, echo timing with timeout, result latch and
// four-character serial report. Optional TX watchdog: TRENA_TX_WATCHDOG_EN.
module trena_controle_medicao
  import trena_pkg::*;
#(
  parameter int unsigned TRIGGER_CICLOS    = TRIGGER_CICLOS_PADRAO,
  parameter int unsigned TIMEOUT_CICLOS    = TIMEOUT_CICLOS_PADRAO,
  parameter int unsigned INTERVALO_CICLOS  = INTERVALO_CICLOS_PADRAO,
  parameter int unsigned TX_TIMEOUT_CICLOS = TX_TIMEOUT_CICLOS_PADRAO
) (
  input  logic                      clock,
  input  logic                      reset,
  trena_controle_medicao_if.master  bus
);

`ifdef TRENA_TX_WATCHDOG_EN
  localparam bit WATCHDOG_TX = 1'b1;
`else
  localparam bit WATCHDOG_TX = 1'b0;
`endif

  localparam logic [31:0] L_TRIG_FIM = 32'(TRIGGER_CICLOS - 1);
  localparam logic [31:0] L_TO_FIM   = 32'(TIMEOUT_CICLOS - 1);
  localparam logic [31:0] L_INT_FIM  = 32'(INTERVALO_CICLOS - 1);
  localparam logic [31:0] L_TX_FIM   = 32'(TX_TIMEOUT_CICLOS - 1);

  estado_t     r_estado;
  estado_t     w_prox;
  logic [31:0] r_cnt;
  logic        w_echo_s;
  logic        r_zera;
  logic        r_trigger;
  logic        r_conta;
  logic        r_registra;
  logic        r_partida_tx;
  logic        r_pronto;
  logic        r_erro;
  logic [1:0]  r_sel_char;

  sincronizador_2ff u_sinc_echo (
    .clock (clock),
    .reset (reset),
    .i_d   (bus.echo),
    .o_q   (w_echo_s)
  );

  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      INICIAL:     if (bus.mensurar) w_prox = PREPARA;
      PREPARA:     w_prox = TRIGGER;
      TRIGGER:     if (r_cnt == L_TRIG_FIM) w_prox = ESPERA_ECHO;
      ESPERA_ECHO: begin
        if (w_echo_s)               w_prox = MEDE;
        else if (r_cnt == L_TO_FIM) w_prox = ERRO;
      end
      MEDE: begin
        if (!w_echo_s)              w_prox = ARMAZENA;
        else if (r_cnt == L_TO_FIM) w_prox = ERRO;
      end
      ARMAZENA:    w_prox = TRANSMITE;
      TRANSMITE:   w_prox = ESPERA_TX;
      ESPERA_TX: begin
        if (bus.tx_pronto)
          w_prox = (r_sel_char == CHAR_HASH) ? FINAL : PROX_CHAR;
        else if (WATCHDOG_TX && (r_cnt == L_TX_FIM))
          w_prox = ERRO;
      end
      PROX_CHAR:   w_prox = TRANSMITE;
      FINAL,
      ERRO:        w_prox = bus.periodico ? INTERVALO : INICIAL;
      INTERVALO: begin
        if (!bus.periodico)          w_prox = INICIAL;
        else if (r_cnt == L_INT_FIM) w_prox = PREPARA;
      end
      default:     w_prox = INICIAL;
    endcase
  end

  // Outputs are decoded from the next state so they line up with r_estado.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado     <= INICIAL;
      r_cnt        <= '0;
      r_zera       <= 1'b0;
      r_trigger    <= 1'b0;
      r_conta      <= 1'b0;
      r_registra   <= 1'b0;
      r_partida_tx <= 1'b0;
      r_pronto     <= 1'b0;
      r_erro       <= 1'b0;
      r_sel_char   <= CHAR_CENTENA;
    end else begin
      r_estado     <= w_prox;
      r_cnt        <= (w_prox != r_estado) ? '0 : r_cnt + 32'd1;
      r_zera       <= (w_prox == PREPARA);
      r_trigger    <= (w_prox == TRIGGER);
      r_conta      <= (w_prox == MEDE);
      r_registra   <= (w_prox == ARMAZENA);
      r_partida_tx <= (w_prox == TRANSMITE);
      r_pronto     <= (w_prox == FINAL);
      if (w_prox == ERRO)
        r_erro <= 1'b1;
      else if (w_prox == PREPARA)
        r_erro <= 1'b0;
      if (w_prox == ARMAZENA)
        r_sel_char <= CHAR_CENTENA;
      else if (w_prox == PROX_CHAR)
        r_sel_char <= r_sel_char + 2'd1;
    end
  end

  assign bus.zera       = r_zera;
  assign bus.trigger    = r_trigger;
  assign bus.conta      = r_conta;
  assign bus.registra   = r_registra;
  assign bus.partida_tx = r_partida_tx;
  assign bus.sel_char   = r_sel_char;
  assign bus.pronto     = r_pronto;
  assign bus.erro       = r_erro;
  assign bus.db_estado  = r_estado;

endmodule

// File: tb/tb_trena_controle_medicao.sv
// Scoreboard bench: expected state-entry events (state, time spent in the
// previous state, sel_char, erro) are queued; a monitor checks each change.
module tb_trena_controle_medicao;

  typedef struct {
    int st;
    int dur;
    int sel;
    int erro;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  bit   tx_hold = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  ev_t  q[$];

  trena_controle_medicao_if bus ();

  trena_controle_medicao #(
    .TRIGGER_CICLOS    (5),
    .TIMEOUT_CICLOS    (100),
    .INTERVALO_CICLOS  (50),
    .TX_TIMEOUT_CICLOS (30)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic push(input int st, input int dur, input int sel, input int erro);
    ev_t e;
    e.st = st; e.dur = dur; e.sel = sel; e.erro = erro;
    q.push_back(e);
  endtask

  // Four characters, each: TRANSMITE 1 cycle, ESPERA_TX 10 cycles.
  task automatic push_tx(input int erro_final);
    for (int i = 0; i < 4; i++) begin
      push(6, 1, i, -1);
      push(7, 1, i, -1);
      push((i == 3) ? 9 : 8, 10, -1, (i == 3) ? erro_final : -1);
    end
  endtask

  task automatic push_medida_normal();
    push(1, -1, -1, 0);
    push(2, 1, -1, -1);
    push(3, 5, -1, -1);
    push(4, 32, -1, -1);
    push(5, 20, 0, -1);
    push_tx(0);
  endtask

  task automatic pulse_mensurar();
    @(posedge clk); #1 bus.mensurar = 1'b1;
    @(posedge clk); #1 bus.mensurar = 1'b0;
  endtask

  task automatic wait_st(input int s, input int maxc, input string nm);
    int n;
    n = 0;
    while (int'(bus.db_estado) != s && n < maxc) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (int'(bus.db_estado) != s) begin
      n_errors++;
      $display("FAIL wait_%s: estado=%0d, required %0d within %0d cycles",
               nm, bus.db_estado, s, maxc);
    end
  endtask

  // Echo rises 30 cycles after ESPERA_ECHO starts and stays high 20 cycles.
  task automatic eco_normal();
    wait_st(3, 100, "espera_echo");
    repeat (29) @(posedge clk);
    #1 bus.echo = 1'b1;
    repeat (20) @(posedge clk);
    #1 bus.echo = 1'b0;
  endtask

  task automatic check_zero(input string nm);
    logic [14:0] got;
    got = {bus.zera, bus.trigger, bus.conta, bus.registra, bus.partida_tx,
           bus.pronto, bus.erro, bus.sel_char, bus.db_estado, 2'b00};
    n_checks++;
    if (got != '0) begin
      n_errors++;
      $display("FAIL %s: outputs=%h, required all zero", nm, got);
    end
  endtask

  // Monitor: one scoreboard entry per state change.
  initial begin
    int   last;
    int   dur;
    ev_t  e;
    logic [5:0] got_o;
    logic [5:0] exp_o;
    last = 0;
    dur  = 0;
    forever begin
      @(negedge clk);
      if (int'(bus.db_estado) != last) begin
        n_checks++;
        if (q.size() == 0) begin
          n_errors++;
          $display("FAIL seq_unexpected: estado=%0d after %0d cycles in %0d, required no change",
                   bus.db_estado, dur, last);
        end else begin
          e = q.pop_front();
          if (int'(bus.db_estado) != e.st || (e.dur >= 0 && dur != e.dur)) begin
            n_errors++;
            $display("FAIL seq: entered %0d after %0d cycles, required %0d after %0d",
                     bus.db_estado, dur, e.st, e.dur);
          end
          if (e.sel >= 0) begin
            n_checks++;
            if (int'(bus.sel_char) != e.sel) begin
              n_errors++;
              $display("FAIL sel_char: state %0d got %0d, required %0d",
                       e.st, bus.sel_char, e.sel);
            end
          end
          if (e.erro >= 0) begin
            n_checks++;
            if (int'(bus.erro) != e.erro) begin
              n_errors++;
              $display("FAIL erro: state %0d got %0d, required %0d",
                       e.st, bus.erro, e.erro);
            end
          end
          n_checks++;
          got_o = {bus.zera, bus.trigger, bus.conta, bus.registra,
                   bus.partida_tx, bus.pronto};
          exp_o = {e.st == 1, e.st == 2, e.st == 4, e.st == 5, e.st == 6, e.st == 9};
          if (got_o != exp_o) begin
            n_errors++;
            $display("FAIL decode: state %0d outputs=%b, required %b",
                     e.st, got_o, exp_o);
          end
        end
        last = int'(bus.db_estado);
        dur  = 1;
      end else begin
        dur++;
      end
    end
  end

  // Serial TX model: tx_pronto pulse 10 cycles after partida_tx.
  initial begin
    bus.tx_pronto = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.partida_tx && !tx_hold) begin
        repeat (10) @(posedge clk);
        #1 bus.tx_pronto = 1'b1;
        @(posedge clk);
        #1 bus.tx_pronto = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1);
  end

  initial begin
    rst_n         = 1'b0;
    bus.mensurar  = 1'b0;
    bus.periodico = 1'b0;
    bus.echo      = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    @(posedge clk); #1 rst_n = 1'b1;

    // Reset while measuring with echo high.
    push(1, -1, -1, 0);
    push(2, 1, -1, -1);
    push(3, 5, -1, -1);
    push(4, 4, -1, -1);
    push(0, -1, -1, -1);
    pulse_mensurar();
    wait_st(3, 50, "rst_espera");
    @(posedge clk); #1 bus.echo = 1'b1;
    wait_st(4, 20, "rst_mede");
    @(negedge clk); #2 rst_n = 1'b0;
    @(negedge clk);
    check_zero("reset_mid_mede");
    bus.echo = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_zero("idle_after_reset");

    // Nominal single-shot measurement.
    push_medida_normal();
    push(0, 1, -1, 0);
    pulse_mensurar();
    eco_normal();
    wait_st(0, 200, "nominal_end");

    // Echo never rises.
    push(1, -1, -1, 0);
    push(2, 1, -1, -1);
    push(3, 5, -1, -1);
    push(14, 100, -1, 1);
    push(0, 1, -1, 1);
    pulse_mensurar();
    wait_st(14, 200, "sem_eco_erro");
    wait_st(0, 10, "sem_eco_fim");

    // Echo stuck high; next mensurar clears erro.
    push(1, -1, -1, 0);
    push(2, 1, -1, -1);
    push(3, 5, -1, -1);
    push(4, 4, -1, -1);
    push(14, 100, -1, 1);
    push(0, 1, -1, 1);
    pulse_mensurar();
    wait_st(3, 50, "preso_espera");
    @(posedge clk); #1 bus.echo = 1'b1;
    wait_st(14, 200, "preso_erro");
    bus.echo = 1'b0;
    wait_st(0, 10, "preso_fim");

    // Periodic: nominal, then timeout (restart clears erro), then nominal and stop.
    bus.periodico = 1'b1;
    push_medida_normal();
    push(10, 1, -1, 0);
    push(1, 50, -1, -1);
    push(2, 1, -1, -1);
    push(3, 5, -1, -1);
    push(14, 100, -1, 1);
    push(10, 1, -1, 1);
    push(1, 50, -1, 0);
    push(2, 1, -1, -1);
    push(3, 5, -1, -1);
    push(4, 32, -1, -1);
    push(5, 20, 0, -1);
    push_tx(0);
    push(10, 1, -1, 0);
    push(0, 1, -1, 0);
    pulse_mensurar();
    eco_normal();
    wait_st(10, 200, "per_intervalo1");
    wait_st(14, 300, "per_erro");
    eco_normal();
    wait_st(10, 200, "per_intervalo2");
    bus.periodico = 1'b0;
    wait_st(0, 5, "per_parada");

    // tx_pronto withheld.
    tx_hold = 1'b1;
    push(1, -1, -1, 0);
    push(2, 1, -1, -1);
    push(3, 5, -1, -1);
    push(4, 32, -1, -1);
    push(5, 20, 0, -1);
    push(6, 1, 0, -1);
    push(7, 1, 0, -1);
`ifdef TRENA_TX_WATCHDOG_EN
    push(14, 30, -1, 1);
    push(0, 1, -1, 1);
    pulse_mensurar();
    eco_normal();
    wait_st(14, 200, "wd_erro");
    wait_st(0, 10, "wd_fim");
`else
    push(0, -1, -1, -1);
    pulse_mensurar();
    eco_normal();
    wait_st(7, 100, "tx_espera");
    repeat (40) @(negedge clk);
    n_checks++;
    if (bus.db_estado != 4'd7) begin
      n_errors++;
      $display("FAIL tx_sem_watchdog: estado=%0d, required 7", bus.db_estado);
    end
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
`endif
    tx_hold = 1'b0;

    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: %0d events pending, required 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
